// File: rtl/mem_port_arbiter_if.sv
// Memory port arbiter bus bundle.
// Groups the per-channel request/response signals and the unified line-memory port.
//   req_valid/req_we/req_addr/req_wdata : per-channel requests (packed, channel i at i*W)
//   req_grant/rsp_valid                 : one-hot per-channel pulses from the arbiter
//   rsp_data                            : shared read-line return bus
//   m_addr/m_re/m_we/m_wdata            : memory command, held until m_rdy
//   m_rdata/m_rdy                       : memory read line and completion
// Modports:
//   master : requesters plus memory model (drives requests and memory responses)
//   slave  : the arbiter itself
interface mem_port_arbiter_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned LINE_W = 64
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_we;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*LINE_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        req_grant;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [LINE_W-1:0]        rsp_data;
    logic [ADDR_W-1:0]        m_addr;
    logic                     m_re;
    logic                     m_we;
    logic [LINE_W-1:0]        m_wdata;
    logic [LINE_W-1:0]        m_rdata;
    logic                     m_rdy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, m_rdata, m_rdy,
        input  req_grant, rsp_valid, rsp_data, m_addr, m_re, m_we, m_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, m_rdata, m_rdy,
        output req_grant, rsp_valid, rsp_data, m_addr, m_re, m_we, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter between L1 caches and the unified line memory.
// Serialises one line read or write-back per transaction onto the single memory port and
// returns completion (and read data) to the requesting channel.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : mem_port_arbiter_if.slave (requests, grants, responses, memory port)
// Configuration:
//   MEM_ARB_FIXED_PRIO_EN defined   : fixed priority, lowest channel index wins.
//   MEM_ARB_FIXED_PRIO_EN undefined : round-robin starting at rr_ptr (default).
// All outputs are registered. Each transaction occupies IDLE -> BUSY -> RESP, so at least
// three cycles.
module mem_port_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned LINE_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned ChW = $clog2((NUM_CH > 2) ? NUM_CH : 2);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   req_grant_q, req_grant_d;
    logic [NUM_CH-1:0]   rsp_valid_q, rsp_valid_d;
    logic [LINE_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic                m_re_q, m_re_d;
    logic                m_we_q, m_we_d;
    logic [LINE_W-1:0]   m_wdata_q, m_wdata_d;
    logic [ChW-1:0]      ch_id_q, ch_id_d;

    // Arbitration result for the current cycle.
    logic                win_found;
    logic [ChW-1:0]      win_id;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [LINE_W-1:0]   win_wdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!win_found && bus.req_valid[i]) begin
                win_found = 1'b1;
                win_id    = ChW'(i);
            end
        end
    end
`else
    logic [ChW-1:0] rr_ptr_q, rr_ptr_d;

    // Circular scan from rr_ptr_q: first look at channels at or above the pointer,
    // then wrap around to the lowest requesting channel.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!win_found && bus.req_valid[i] && (ChW'(i) >= rr_ptr_q)) begin
                win_found = 1'b1;
                win_id    = ChW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!win_found && bus.req_valid[i]) begin
                win_found = 1'b1;
                win_id    = ChW'(i);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == StIdle && win_found) begin
            rr_ptr_d = (win_id == ChW'(NUM_CH - 1)) ? '0 : win_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Winner's request fields.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ChW'(i) == win_id) begin
                win_we    = bus.req_we[i];
                win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = bus.req_wdata[i*LINE_W +: LINE_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_grant_d = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_re_d      = m_re_q;
        m_we_d      = m_we_q;
        ch_id_d     = ch_id_q;

        unique case (state_q)
            StIdle: begin
                m_re_d = 1'b0;
                m_we_d = 1'b0;
                if (win_found) begin
                    m_addr_d  = win_addr;
                    m_wdata_d = win_wdata;
                    m_re_d    = !win_we;
                    m_we_d    = win_we;
                    ch_id_d   = win_id;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        req_grant_d[i] = (ChW'(i) == win_id);
                    end
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Command stays stable until the memory completes.
                if (bus.m_rdy) begin
                    m_re_d = 1'b0;
                    m_we_d = 1'b0;
                    if (m_re_q) begin
                        rsp_data_d = bus.m_rdata;
                    end
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        rsp_valid_d[i] = (ChW'(i) == ch_id_q);
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_grant_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            m_addr_q    <= '0;
            m_re_q      <= 1'b0;
            m_we_q      <= 1'b0;
            m_wdata_q   <= '0;
            ch_id_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_grant_q <= req_grant_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            m_addr_q    <= m_addr_d;
            m_re_q      <= m_re_d;
            m_we_q      <= m_we_d;
            m_wdata_q   <= m_wdata_d;
            ch_id_q     <= ch_id_d;
        end
    end

    assign bus.req_grant = req_grant_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_re      = m_re_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (NUM_CH=2, ADDR_W=14, LINE_W=64).
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if #(.NUM_CH(2), .ADDR_W(14), .LINE_W(64)) bus ();

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(14), .LINE_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [1:0]  exp_g [4];
    logic [13:0] exp_a;
    int          ntx;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.m_rdata   = '0;
        bus.m_rdy     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_grant", bus.req_grant, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_m_re", bus.m_re, 0);
        check("rst_m_we", bus.m_we, 0);
        check("rst_m_wdata", bus.m_wdata, 0);
        rst = 1'b0;

        // Spurious m_rdy while idle
        bus.m_rdy   = 1'b1;
        bus.m_rdata = 64'hFFFF_0000_FFFF_0000;
        tick();
        check("spur_rsp_valid", bus.rsp_valid, 0);
        check("spur_rsp_data", bus.rsp_data, 0);
        check("spur_m_re", bus.m_re, 0);
        tick();
        check("spur_grant", bus.req_grant, 0);
        check("spur_rsp_valid2", bus.rsp_valid, 0);
        bus.m_rdy = 1'b0;

        // Single read, ch1, memory completes in the 4th busy cycle
        bus.req_valid        = 2'b10;
        bus.req_we           = 2'b00;
        bus.req_addr[14+:14] = 14'h2C3F;
        tick();
        check("rd_grant", bus.req_grant, 2'b10);
        check("rd_m_re_b1", bus.m_re, 1);
        check("rd_m_we", bus.m_we, 0);
        check("rd_m_addr", bus.m_addr, 14'h2C3F);
        bus.req_valid = 2'b00;
        tick();
        check("rd_grant_b2", bus.req_grant, 0);
        check("rd_m_re_b2", bus.m_re, 1);
        tick();
        check("rd_m_re_b3", bus.m_re, 1);
        tick();
        check("rd_m_re_b4", bus.m_re, 1);
        check("rd_rsp_early", bus.rsp_valid, 0);
        bus.m_rdy   = 1'b1;
        bus.m_rdata = 64'hDEAD_BEEF_0123_4567;
        tick();
        check("rd_rsp_valid", bus.rsp_valid, 2'b10);
        check("rd_rsp_data", bus.rsp_data, 64'hDEAD_BEEF_0123_4567);
        check("rd_m_re_done", bus.m_re, 0);
        bus.m_rdy = 1'b0;
        tick();
        check("rd_rsp_pulse", bus.rsp_valid, 0);
        check("rd_rsp_hold", bus.rsp_data, 64'hDEAD_BEEF_0123_4567);

        // Write-back, ch1, 1-cycle memory
        bus.req_valid          = 2'b10;
        bus.req_we             = 2'b10;
        bus.req_addr[14+:14]   = 14'h0010;
        bus.req_wdata[64+:64]  = 64'h1111_2222_3333_4444;
        tick();
        check("wb_grant", bus.req_grant, 2'b10);
        check("wb_m_we", bus.m_we, 1);
        check("wb_m_re", bus.m_re, 0);
        check("wb_m_addr", bus.m_addr, 14'h0010);
        check("wb_m_wdata", bus.m_wdata, 64'h1111_2222_3333_4444);
        bus.req_valid = 2'b00;
        bus.req_we    = 2'b00;
        bus.m_rdy     = 1'b1;
        bus.m_rdata   = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        check("wb_rsp_valid", bus.rsp_valid, 2'b10);
        check("wb_rsp_data_kept", bus.rsp_data, 64'hDEAD_BEEF_0123_4567);
        check("wb_m_we_done", bus.m_we, 0);
        bus.m_rdy = 1'b0;
        tick();
        check("wb_rsp_pulse", bus.rsp_valid, 0);

        // Contention from reset, memory ready every cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_g[0] = 2'b01;
        exp_g[1] = 2'b01;
        exp_g[2] = 2'b10;
        exp_g[3] = 2'b00;
        ntx      = 3;
`else
        exp_g[0] = 2'b01;
        exp_g[1] = 2'b10;
        exp_g[2] = 2'b01;
        exp_g[3] = 2'b10;
        ntx      = 4;
`endif
        bus.req_addr[0+:14]  = 14'h0AAA;
        bus.req_addr[14+:14] = 14'h1555;
        bus.m_rdata          = 64'hA5A5_5A5A_C3C3_3C3C;
        bus.m_rdy            = 1'b1;
        bus.req_valid        = 2'b11;
        for (int k = 0; k < ntx; k++) begin
            exp_a = (exp_g[k] == 2'b01) ? 14'h0AAA : 14'h1555;
            tick();
            check($sformatf("cont_grant_%0d", k), bus.req_grant, exp_g[k]);
            check($sformatf("cont_addr_%0d", k), bus.m_addr, exp_a);
`ifdef MEM_ARB_FIXED_PRIO_EN
            if (k == 1) bus.req_valid[0] = 1'b0;
`endif
            tick();
            check($sformatf("cont_rsp_%0d", k), bus.rsp_valid, exp_g[k]);
            check($sformatf("cont_nodup_resp_%0d", k), bus.req_grant, 0);
            check($sformatf("cont_rsp_data_%0d", k), bus.rsp_data, 64'hA5A5_5A5A_C3C3_3C3C);
            tick();
            check($sformatf("cont_idle_rsp_%0d", k), bus.rsp_valid, 0);
            check($sformatf("cont_nodup_idle_%0d", k), bus.req_grant, 0);
        end
        bus.req_valid = 2'b00;
        bus.m_rdy     = 1'b0;
        tick();
        check("cont_quiet", bus.req_grant, 0);

        // Reset during busy of a ch0 read
        bus.req_valid       = 2'b01;
        bus.req_addr[0+:14] = 14'h0123;
        tick();
        check("rm_grant", bus.req_grant, 2'b01);
        check("rm_m_re", bus.m_re, 1);
        bus.req_valid = 2'b00;
        tick();
        check("rm_m_re_b2", bus.m_re, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_m_re_rst", bus.m_re, 0);
        check("rm_rsp_rst", bus.rsp_valid, 0);
        check("rm_m_addr_rst", bus.m_addr, 0);
        check("rm_rsp_data_rst", bus.rsp_data, 0);
        bus.m_rdy = 1'b1;
        tick();
        check("rm_idle_rsp", bus.rsp_valid, 0);
        check("rm_idle_m_re", bus.m_re, 0);
        bus.m_rdy            = 1'b0;
        bus.req_valid        = 2'b10;
        bus.req_addr[14+:14] = 14'h3FFF;
        tick();
        check("rm_new_grant", bus.req_grant, 2'b10);
        check("rm_new_addr", bus.m_addr, 14'h3FFF);
        check("rm_new_m_re", bus.m_re, 1);
        bus.req_valid = 2'b00;
        bus.m_rdy     = 1'b1;
        bus.m_rdata   = 64'h0F0F_1234_5678_9ABC;
        tick();
        check("rm_new_rsp", bus.rsp_valid, 2'b10);
        check("rm_new_data", bus.rsp_data, 64'h0F0F_1234_5678_9ABC);
        bus.m_rdy = 1'b0;
        tick();
        check("rm_new_rsp_pulse", bus.rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
